// File: rtl/path_delay_meter.sv
// Launch/capture controller for one spy delay chain: launches alternating edges, times their
// synchronized arrival and averages 2**TRIALS_LOG2 trials. Define PATH_DELAY_MINMAX_EN for delay_min/delay_max.
module path_delay_meter #(
  parameter int CNT_W       = 16,
  parameter int TRIALS_LOG2 = 3,
  parameter int TIMEOUT     = 1023,
  parameter int SETTLE_CYC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             path_launch,
  input  logic             path_capture,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] delay_last,
  output logic [CNT_W-1:0] delay_avg
`ifdef PATH_DELAY_MINMAX_EN
  ,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max
`endif
);

  localparam int NUM_TRIALS = 1 << TRIALS_LOG2;
  localparam int SUM_W      = CNT_W + TRIALS_LOG2;
  localparam int IDX_W      = (TRIALS_LOG2 > 0) ? TRIALS_LOG2 : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TRIALS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LAUNCH,
    S_MEASURE,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic             sync_q1, cap_s;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [SUM_W-1:0] sum_q;
  logic [IDX_W-1:0] trial_q;
  logic             arrived;
  logic             accept;
  logic             hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      cap_s   <= 1'b0;
    end else begin
      sync_q1 <= path_capture;
      cap_s   <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_inc = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_q + CNT_W'(1);
    arrived = (cap_s == path_launch);
    accept  = (state_q == S_IDLE) && start;
    hit     = (state_q == S_MEASURE) && arrived;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ARM;
      S_ARM: begin
        if (arrived)                  state_d = S_LAUNCH;
        else if (cnt_inc >= TIMEOUT_C) state_d = S_FAIL;
      end
      S_LAUNCH:  state_d = S_MEASURE;
      S_MEASURE: begin
        // An arrival on the same edge the count saturates still counts as success.
        if (arrived)                  state_d = S_SETTLE;
        else if (cnt_inc >= TIMEOUT_C) state_d = S_FAIL;
      end
      S_SETTLE: begin
        if (cnt_inc >= SETTLE_C) state_d = (trial_q == LAST_IDX) ? S_DONE : S_LAUNCH;
      end
      S_DONE:    state_d = S_IDLE;
      S_FAIL:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_launch <= 1'b0;
      timeout_err <= 1'b0;
      delay_last  <= '0;
      delay_avg   <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      trial_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q       <= '0;
            sum_q       <= '0;
            trial_q     <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_ARM, S_SETTLE: cnt_q <= cnt_inc;
        S_LAUNCH:        cnt_q <= '0;
        S_MEASURE: begin
          if (hit) begin
            delay_last <= cnt_inc;
            sum_q      <= sum_q + SUM_W'(cnt_inc);
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase

      // The launch edge is the one entering LAUNCH, so LAUNCH is the first cycle at the new level.
      if (state_d == S_LAUNCH) path_launch <= ~path_launch;
      if (state_q == S_SETTLE && state_d == S_LAUNCH) trial_q <= trial_q + IDX_W'(1);
      if (state_d == S_DONE) delay_avg <= CNT_W'(sum_q >> TRIALS_LOG2);
      if (state_d == S_FAIL) begin
        timeout_err <= 1'b1;
        path_launch <= 1'b0;
      end
    end
  end

`ifdef PATH_DELAY_MINMAX_EN
  logic [CNT_W-1:0] run_min_q, run_max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min_q <= '1;
      run_max_q <= '0;
      delay_min <= '0;
      delay_max <= '0;
    end else begin
      if (accept) begin
        run_min_q <= '1;
        run_max_q <= '0;
      end else if (hit) begin
        if (cnt_inc < run_min_q) run_min_q <= cnt_inc;
        if (cnt_inc > run_max_q) run_max_q <= cnt_inc;
      end
      if (state_d == S_DONE) begin
        delay_min <= run_min_q;
        delay_max <= run_max_q;
      end
    end
  end
`endif

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) || (state_q == S_FAIL);

endmodule

// File: doc/path_delay_meter.md
Name: path_delay_meter

Overview:
- Launch/capture controller for one spy delay chain (20-stage spypath instance).
- Drives the chain input with alternating transitions and counts clock edges until each transition emerges, synchronized, at the chain output.
- Accumulates 2^TRIALS_LOG2 trials and reports the average delay, which feeds the Trojan-detection comparison logic downstream.
- Sits between the detection control FSM (start/result) and the delay chain (pathInput/pathResult).

Parameters:
- CNT_W, 16, width of the per-trial cycle counter and of the reported delays.
- TRIALS_LOG2, 3, log2 of trials per measurement (default 8 trials, alternating rising/falling launches).
- TIMEOUT, 1023, max cycles waited in ARM or MEASURE before abort; must be < 2^CNT_W.
- SETTLE_CYC, 8, idle cycles between a detected arrival and the next launch.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a measurement; ignored while busy=1.
- path_launch  out  1  registered drive to chain pathInput.
- path_capture  in  1  chain pathResult, asynchronous to clk; double-flop synchronized internally.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when a measurement ends (success or timeout).
- timeout_err  out  1  valid with done; held until the next accepted start.
- delay_last  out  CNT_W  count of the most recent successful trial.
- delay_avg  out  CNT_W  sum of the trials >> TRIALS_LOG2 (truncating); updated only on success.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; path_launch=0; busy=0; done=0; timeout_err=0; delay_last=0; delay_avg=0; sync flops=0; sum, trial index and counter cleared.
- Synchronizer: cap_s = path_capture after two clk flops. Only cap_s is used.
- FSM states:
  - IDLE: start=1 → ARM. Clears sum, trial index and timeout_err.
  - ARM: waits for cap_s == path_launch (chain quiescent), counting cycles. On match → LAUNCH. If the count reaches TIMEOUT → FAIL.
  - LAUNCH: toggles path_launch for one cycle, clears counter → MEASURE.
  - MEASURE: counter increments every edge. On the first edge where cap_s equals the new path_launch level:
    - delay_last ← counter value including that edge;
    - sum += delay_last;
    - → SETTLE.
    - If the counter reaches TIMEOUT with no match → FAIL.
  - SETTLE: waits SETTLE_CYC cycles. If trial index == 2^TRIALS_LOG2−1 → DONE; else index++ and → LAUNCH.
  - DONE: delay_avg ← sum >> TRIALS_LOG2; done=1 for one cycle → IDLE.
  - FAIL: timeout_err=1; done=1 for one cycle; delay_avg and delay_last hold their prior values; path_launch forced to 0 → IDLE.
- Counting rule: the count runs from the launch edge (exclusive) to the detecting edge (inclusive). A chain modelled as D full clock cycles of delay yields D+2, the +2 being synchronizer latency. No correction is applied.
- Widths: sum register is CNT_W+TRIALS_LOG2 bits and cannot overflow. The counter saturates at TIMEOUT.
- Trial polarity: trials alternate edges, starting from the current path_launch level. Default start level 0 gives rising, falling, rising, ...
- Simultaneous events:
  - start while busy: ignored.
  - start on the same cycle as done: ignored.
  - A match on the same edge the counter hits TIMEOUT counts as success.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no done pulse.

Optional Feature:
- Macro: PATH_DELAY_MINMAX_EN.
- When defined:
  - Adds outputs delay_min and delay_max (CNT_W each), updated on DONE with the min/max of the successful trials in that measurement.
  - Both reset to 0 and hold their values on FAIL.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Bench models the chain as D register stages; D=5, defaults, start pulse → 8 trials, delay_last=7, delay_avg=7, done pulse, timeout_err=0, busy high throughout.
- Asymmetric chain: rising D=4, falling D=6 → delay_avg=(4×6+4×8)/8=7, delay_last=8 (last trial is falling).
- Chain output stuck at 0 → first rising trial hits TIMEOUT=1023. FAIL: done with timeout_err=1, delay_avg keeps its previous value 7, path_launch=0.
- Assert rst_n=0 during MEASURE of trial 3 → all outputs 0 immediately, no done. A subsequent start with D=5 → delay_avg=7.
- start pulses on the cycles busy=1 and on the done cycle are ignored (exactly one done per accepted start). A start 1 cycle after done is accepted.
- PATH_DELAY_MINMAX_EN defined, D alternating 3 (rising) / 9 (falling) → delay_min=5, delay_max=11, delay_avg=8.
